// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   UART_DATA_BITS - payload bits per 8N1 frame
//   LINE_IDLE      - level of an idle serial line
//   rx_state_e     - receive FSM state encoding
package uart_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic LINE_IDLE      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO holding received bytes.
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - synchronous active-low reset (pointers and count to 0)
//   push_i   - write din_i; accepted when not full, or when a pop happens too
//   pop_i    - remove head entry; ignored when empty
//   din_i    - write data
//   dout_o   - head entry, forced to 0 while empty
//   count_o  - occupancy, 0..DEPTH
//   full_o   - count_o == DEPTH
//   empty_o  - count_o == 0
// Handshake: the consumer side is valid/ready -- valid is !empty_o, and an
// entry leaves on any edge where pop_i is high while the FIFO is not empty.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still lands when the consumer is reading at that moment.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: dout_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver with a byte FIFO on its output.
// Ports:
//   clock         - clock, rising edge
//   reset_n       - synchronous active-low reset
//   Data_in       - serial line, idles high
//   Data_out      - FIFO head byte, meaningful while valid = 1
//   valid         - FIFO not empty
//   ready         - consumer takes the head byte when valid && ready
//   count         - FIFO occupancy
//   framing_error - one-cycle pulse after a stop bit sampled low
//   overrun       - sticky; a good byte was dropped because the FIFO was full
//   clear_err     - clears overrun (a simultaneous new overrun wins)
//   dbg_state     - current receive FSM state
// Handshake: valid/ready. Data_out is stable while valid && !ready; a byte
// is consumed on every rising edge with valid && ready, and the next entry
// shows on Data_out in the following cycle.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int clks_per_bit = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          Data_in,
  output logic [UART_DATA_BITS-1:0]     Data_out,
  output logic                          valid,
  input  logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          framing_error,
  output logic                          overrun,
  input  logic                          clear_err,
  output rx_state_e                     dbg_state
);

  localparam int             TW       = $clog2(clks_per_bit + 1);
  localparam logic [TW-1:0]  HALF     = TW'(clks_per_bit / 2);
  localparam logic [TW-1:0]  BIT_LAST = TW'(clks_per_bit - 1);

  logic                      sync1_q, rx_s_q;
  rx_state_e                 state_q;
  logic [TW-1:0]             timer_q;
  logic [2:0]                bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      ferr_q;
  logic                      overrun_q;
  logic                      push_req;
  logic                      fifo_full, fifo_empty;

  // Two-flop synchronizer; both stages reset to the idle level so a reset
  // never looks like a start bit.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= LINE_IDLE;
      rx_s_q  <= LINE_IDLE;
    end else begin
      sync1_q <= Data_in;
      rx_s_q  <= sync1_q;
    end
  end

  // Receive FSM. The timer counts 0..HALF in START and 0..BIT_LAST per bit
  // in DATA/STOP, so the start bit is sampled HALF+1 cycles after IDLE sees
  // the falling edge and every later sample follows clks_per_bit apart.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ferr_q    <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          timer_q   <= '0;
          bit_idx_q <= '0;
          if (rx_s_q != LINE_IDLE) state_q <= ST_START;
        end
        ST_START: begin
          if (timer_q == HALF) begin
            timer_q   <= '0;
            bit_idx_q <= '0;
            // A line that is high again at mid-start was a glitch.
            state_q   <= (rx_s_q == LINE_IDLE) ? ST_IDLE : ST_DATA;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_DATA: begin
          if (timer_q == BIT_LAST) begin
            timer_q   <= '0;
            shift_q   <= {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'(UART_DATA_BITS - 1)) state_q <= ST_STOP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_STOP: begin
          if (timer_q == BIT_LAST) begin
            timer_q   <= '0;
            bit_idx_q <= '0;
            if (rx_s_q == LINE_IDLE) begin
              state_q <= ST_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_WAIT_HIGH;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_WAIT_HIGH: begin
          // Hold off during a break so a long low is not re-read as starts.
          timer_q   <= '0;
          bit_idx_q <= '0;
          if (rx_s_q == LINE_IDLE) state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          timer_q   <= '0;
          bit_idx_q <= '0;
        end
      endcase
    end
  end

  // The push is decoded from the stop-bit sample so the FIFO write lands on
  // the same edge that samples the stop bit.
  assign push_req = (state_q == ST_STOP) && (timer_q == BIT_LAST) &&
                    (rx_s_q == LINE_IDLE);

  uart_rx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (push_req),
    .pop_i   (ready),
    .din_i   (shift_q),
    .dout_o  (Data_out),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Full implies valid, so a drop happens exactly when ready is low.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
    end else if (push_req && fifo_full && !ready) begin
      overrun_q <= 1'b1;
    end else if (clear_err) begin
      overrun_q <= 1'b0;
    end
  end

  assign valid         = !fifo_empty;
  assign framing_error = ferr_q;
  assign overrun       = overrun_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
module tb_uart_rx_buffered;
  import uart_pkg::*;

  localparam int C     = 4;
  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       Data_in;
  logic [7:0] Data_out;
  logic       valid;
  logic       ready;
  logic [3:0] count;
  logic       framing_error;
  logic       overrun;
  logic       clear_err;
  rx_state_e  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int ferr_cycles = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_ferr;
  } vec_t;
  vec_t vecs[8];

  uart_rx_buffered #(.clks_per_bit(C), .FIFO_DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .Data_in       (Data_in),
    .Data_out      (Data_out),
    .valid         (valid),
    .ready         (ready),
    .count         (count),
    .framing_error (framing_error),
    .overrun       (overrun),
    .clear_err     (clear_err),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clock) if (framing_error === 1'b1) ferr_cycles++;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; frame occupies the next 10*C cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      Data_in = bits[i];
      repeat (C) tick();
    end
    Data_in = 1'b1;
  endtask

  task automatic read_byte(input string name);
    int budget;
    logic [7:0] e;
    budget = 300;
    while (valid !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    @(negedge clock);
    if (valid !== 1'b1) begin
      check({name, " valid timeout"}, 32'(valid), 32'd1);
    end else begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      check(name, 32'(Data_out), 32'(e));
      ready = 1'b1;
      tick();
      ready = 1'b0;
    end
  endtask

  task automatic drain(input string name, input int n);
    for (int i = 0; i < n; i++) read_byte(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int f0;
    Data_in   = 1'b1;
    ready     = 1'b0;
    clear_err = 1'b0;
    reset_n   = 1'b0;

    vecs[0] = '{8'h3C, 1'b0, 1};
    vecs[1] = '{8'h55, 1'b1, 0};
    vecs[2] = '{8'h00, 1'b1, 0};
    vecs[3] = '{8'hFF, 1'b1, 0};
    vecs[4] = '{8'($urandom_range(0, 255)), 1'b1, 0};
    vecs[5] = '{8'($urandom_range(0, 255)), 1'b0, 1};
    vecs[6] = '{8'($urandom_range(0, 255)), 1'b1, 0};
    vecs[7] = '{8'h01, 1'b1, 0};

    // Reset state
    repeat (3) tick();
    @(negedge clock);
    check("reset valid", 32'(valid), 0);
    check("reset count", 32'(count), 0);
    check("reset data_out", 32'(Data_out), 0);
    check("reset framing_error", 32'(framing_error), 0);
    check("reset overrun", 32'(overrun), 0);
    check("reset state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // Single frame with latency check: write edge closes cycle k+41
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick();
    @(negedge clock);
    check("latency valid early", 32'(valid), 0);
    tick();
    @(negedge clock);
    check("latency valid", 32'(valid), 1);
    check("single count", 32'(count), 1);
    read_byte("single data");
    @(negedge clock);
    check("single valid after pop", 32'(valid), 0);
    check("single count after pop", 32'(count), 0);
    tick();

    // Glitch rejection
    f0 = ferr_cycles;
    Data_in = 1'b0;
    tick();
    Data_in = 1'b1;
    repeat (12) tick();
    @(negedge clock);
    check("glitch count", 32'(count), 0);
    check("glitch ferr", 32'(ferr_cycles - f0), 0);
    check("glitch state", 32'(dbg_state), 32'(ST_IDLE));
    tick();

    // Table-driven frames, including framing errors with a held-low line
    foreach (vecs[i]) begin
      f0 = ferr_cycles;
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      if (!vecs[i].stop) begin
        Data_in = 1'b0;
        repeat (20) tick();
        Data_in = 1'b1;
      end
      repeat (8) tick();
      @(negedge clock);
      check($sformatf("vec%0d ferr", i), 32'(ferr_cycles - f0), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d count", i), 32'(count), 32'(exp_q.size()));
      tick();
    end
    drain("vec data", exp_q.size());
    @(negedge clock);
    check("vec drained count", 32'(count), 0);
    tick();

    // Overrun: nine back-to-back frames into an eight-deep FIFO
    for (int i = 0; i < 9; i++) begin
      if (i < DEPTH) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    repeat (6) tick();
    @(negedge clock);
    check("overrun count", 32'(count), 8);
    check("overrun flag", 32'(overrun), 1);
    tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    @(negedge clock);
    check("overrun cleared", 32'(overrun), 0);
    tick();
    drain("overrun data", 8);
    @(negedge clock);
    check("overrun drained count", 32'(count), 0);
    tick();

    // Push/pop collision at full: ready high exactly on the 9th write cycle
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'(8'h10 + i));
      send_frame(8'(8'h10 + i), 1'b1);
    end
    exp_q.push_back(8'h18);
    fork
      send_frame(8'h18, 1'b1);
      begin
        logic [7:0] e;
        repeat (41) tick();
        ready = 1'b1;
        @(negedge clock);
        check("collision count before", 32'(count), 8);
        e = exp_q.pop_front();
        check("collision head", 32'(Data_out), 32'(e));
        tick();
        ready = 1'b0;
      end
    join
    repeat (4) tick();
    @(negedge clock);
    check("collision count", 32'(count), 8);
    check("collision overrun", 32'(overrun), 0);
    tick();
    drain("collision data", 8);
    tick();

    // Reset mid-frame (DATA bit 4); the frame's remaining bits are all high
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    repeat (6) tick();
    @(negedge clock);
    check("pre-reset count", 32'(count), 1);
    tick();
    fork
      send_frame(8'hF5, 1'b1);
      begin
        repeat (23) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clock);
        check("midreset valid", 32'(valid), 0);
        check("midreset count", 32'(count), 0);
        check("midreset data_out", 32'(Data_out), 0);
        check("midreset overrun", 32'(overrun), 0);
        check("midreset ferr", 32'(framing_error), 0);
        check("midreset state", 32'(dbg_state), 32'(ST_IDLE));
        exp_q.delete();
      end
    join
    repeat (8) tick();
    @(negedge clock);
    check("post-reset count", 32'(count), 0);
    tick();
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    read_byte("post-reset data");
    @(negedge clock);
    check("final count", 32'(count), 0);
    check("final scoreboard", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Buffered UART receive front-end for the serial line driven by the team's transmitter: receives 8N1 frames at `clks_per_bit` clocks per bit and stores complete bytes in a small synchronous FIFO. The consumer reads bytes through a ready/valid handshake. The block also reports framing errors and FIFO overruns. It sits on the receive side of the serial link, between the line and any byte-oriented consumer, wherever a bare receiver would lose bytes to a slow reader.

## Interface
- `clks_per_bit`, 2, clock cycles per serial bit; legal range ≥ 2.
- `FIFO_DEPTH`, 8, number of byte entries; must be a power of two, ≥ 2.
- `clock  input  1` — single clock; all logic is rising-edge.
- `reset_n  input  1` — reset is synchronous and active-low.
- `Data_in  input  1` — serial line; idles high.
- `Data_out  output  8` — byte at the FIFO head; valid only while `valid`=1.
- `valid  output  1` — FIFO not empty.
- `ready  input  1` — consumer accepts the head byte when `valid && ready`.
- `count  output  $clog2(FIFO_DEPTH)+1` — current FIFO occupancy.
- `framing_error  output  1` — one-cycle pulse when a stop bit is sampled low.
- `overrun  output  1` — sticky flag; set when a good byte arrives while the FIFO is full.
- `clear_err  input  1` — clears `overrun`.

## Operation
- `Data_in` passes through a 2-FF synchronizer, called `rx_s` below. It resets to 1.
- **Receive FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH. The bit-timer and the 3-bit bit index reset to 0 on every state entry.
- **IDLE:** when `rx_s`=0, go to START.
- **START:** wait `clks_per_bit/2` cycles (floor), then sample `rx_s`.
  - Sample 0: go to DATA.
  - Sample 1: treat as a glitch and return to IDLE. Nothing is pushed and no error is raised.
- **DATA:** wait `clks_per_bit` cycles, then sample one bit into a shift register, LSB first. After the 8th bit, go to STOP.
- **STOP:** wait `clks_per_bit` cycles, then sample `rx_s`.
  - Sample 1: request a push of the assembled byte and go to IDLE.
  - Sample 0: pulse `framing_error`, discard the byte and go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s`=1, then go to IDLE. This stops a break condition from being read as repeated start bits.
- **Push rule:** the push is accepted if `count < FIFO_DEPTH`, or if a pop happens in the same cycle. Otherwise the byte is dropped and `overrun` is set.
- **Pop:** occurs when `valid && ready`. `Data_out` then shows the next entry on the following cycle.
- **Simultaneous push and pop:** `count` is unchanged and both operations take effect. When the FIFO is empty, a pop cannot happen, so the pushed byte appears on the next cycle.
- **Pointers:** read and write pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally. `count` saturates correctly at 0 and at `FIFO_DEPTH`.
- **`clear_err`:** clears `overrun` on the next edge. If a new overrun occurs in the same cycle, the set wins.

## Timing
- **Reset values:** `valid`=0, `count`=0, `Data_out`=0, `framing_error`=0, `overrun`=0. The FSM is in IDLE, the pointers are 0 and `rx_s`=1.
- **Reset mid-frame:** a partial frame is dropped and FIFO contents are lost.
- **Line to FSM:** 2 cycles from a `Data_in` edge to `rx_s`.
- **Frame latency:**
  - Let t0 be the cycle in which IDLE sees `rx_s`=0.
  - The stop bit is sampled at t0 + 1 + `clks_per_bit/2` + 9·`clks_per_bit`.
  - The FIFO write occurs on that edge.
  - `valid` rises, and `count` increments, in the following cycle.
- **Frame spacing:** back-to-back frames with no idle gap are received without loss, because IDLE is re-entered before the next start bit's midpoint.
- **`framing_error`:** high for exactly one cycle, on the cycle after the stop-bit sample.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state encoding for the five states.
  - `UART_DATA_BITS`=8.
  - Idle line level constant = 1.
- **Sub-module `uart_rx_fifo`:**
  - Synchronous FIFO parameterized by width and depth.
  - Ports: push, pop, din, dout, count, full, empty.
- The top level holds the synchronizer, the FSM and the bit-timer, and instantiates `uart_rx_fifo`.

## Test plan
- **Single frame:** `clks_per_bit`=4; transmitter sends 0xA5 with `ready`=0 → `valid`=1, `Data_out`=0xA5, `count`=1. Pulsing `ready` for one cycle → `valid`=0, `count`=0.
- **Glitch rejection:** `Data_in` low for 1 cycle while idle → FSM returns to IDLE, `count`=0, no `framing_error`.
- **Framing error:** frame 0x3C with the stop bit held low, then the line held low for 20 cycles → one `framing_error` pulse, `count` unchanged. The next good frame 0x55 is received correctly.
- **Overrun:** `FIFO_DEPTH`=8, `ready`=0, 9 back-to-back frames 0x00 to 0x08 → `count`=8, `overrun`=1. Reads return 0x00 to 0x07. `clear_err` clears `overrun`.
- **Push/pop collision at full:** FIFO full, and `ready`=1 on the exact cycle of the 9th byte's write → no overrun, `count` stays 8, and the read order includes the 9th byte last.
- **Reset mid-frame:** assert `reset_n`=0 for 1 cycle during DATA bit 4 → all outputs at reset values. A subsequent frame 0x81 is received correctly.
